// File: rtl/am2922_bitdist.sv
// 8-bit addressable bit distributor: addressed write, auto-increment fill or shift-in.
// Optional tristate readback of the selected bit when AM2922_BITDIST_RDBK_EN is defined.
module am2922_bitdist #(
    parameter int unsigned WIDTH = 8,
    parameter logic [7:0]  INIT  = 8'h00
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             pol,
    input  logic             re_,
    input  logic             d,
    input  logic             we_,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             done
`ifdef AM2922_BITDIST_RDBK_EN
    ,
    input  logic             oe_,
    output logic             y
`endif
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_ADDR  = 2'b01,
        MODE_AUTO  = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_t;

    logic [2:0] selreg;
    logic       polreg;
    logic [2:0] ptr;
    logic [2:0] cnt;
    logic       db;
    mode_t      mode_e;

    assign db     = d ^ polreg;
    assign mode_e = mode_t'(mode);

    always_ff @(posedge clk) begin
        if (clr) begin
            q      <= INIT[WIDTH-1:0];
            selreg <= '0;
            polreg <= 1'b0;
            ptr    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!we_) begin
                unique case (mode_e)
                    MODE_HOLD: ;
                    MODE_ADDR: q[selreg] <= db;
                    MODE_AUTO: begin
                        q[ptr] <= db;
                        ptr    <= ptr + 3'd1;
                        cnt    <= cnt + 3'd1;
                        done   <= (cnt == 3'd7);
                    end
                    MODE_SHIFT: begin
                        q    <= {q[WIDTH-2:0], db};
                        cnt  <= cnt + 3'd1;
                        done <= (cnt == 3'd7);
                    end
                    default: ;
                endcase
            end
            // Placed after the write so a simultaneous load wins for ptr/cnt,
            // while the write itself still used the pre-edge register values.
            if (!re_) begin
                selreg <= {c, b, a};
                polreg <= pol;
                ptr    <= {c, b, a};
                cnt    <= '0;
            end
        end
    end

`ifdef AM2922_BITDIST_RDBK_EN
    logic yp;
    assign yp = q[selreg] ^ polreg;
    assign y  = oe_ ? 1'bz : yp;
`endif

endmodule
